// File: rtl/pong_pkg.sv
// Shared Pong constants, bus widths, winner encoding and the paddle clamp/step helper.
package pong_pkg;

  localparam int X_MAX    = 640;
  localparam int Y_MAX    = 480;
  localparam int PADDLE_H = 64;
  localparam int PADDLE_W = 10;

  localparam int X_W = 10;
  localparam int Y_W = 9;

  typedef enum logic [1:0] {
    WIN_NONE = 2'd0,
    WIN_P1   = 2'd1,
    WIN_P2   = 2'd2
  } winner_e;

  // Next top edge for one paddle; math is done 10 bits wide so top+step cannot wrap.
  function automatic logic [Y_W-1:0] next_top(input logic [Y_W-1:0] top,
                                               input logic           up,
                                               input logic           down,
                                               input logic [X_W-1:0] step,
                                               input logic [X_W-1:0] top_max);
    logic [X_W-1:0] t;
    logic [X_W-1:0] sum;
    logic [X_W-1:0] res;
    t   = {1'b0, top};
    sum = t + step;
    res = t;
    if (up && !down)
      res = (t < step) ? '0 : t - step;
    else if (down && !up)
      res = (sum > top_max) ? top_max : sum;
    return res[Y_W-1:0];
  endfunction

endpackage

// File: rtl/paddle_controller_if.sv
// Button/frame inputs and paddle bounding-box outputs of paddle_controller.
interface paddle_controller_if;
  import pong_pkg::*;

  logic           screenEnd;
  logic           p1_up;
  logic           p1_down;
  logic           p2_up;
  logic           p2_down;
  logic [1:0]     winner;
  logic           posEdgeScreenEnd;
  logic [X_W-1:0] p1_leftBound;
  logic [X_W-1:0] p1_rightBound;
  logic [X_W-1:0] p2_leftBound;
  logic [X_W-1:0] p2_rightBound;
  logic [Y_W-1:0] p1_topBound;
  logic [Y_W-1:0] p1_bottomBound;
  logic [Y_W-1:0] p2_topBound;
  logic [Y_W-1:0] p2_bottomBound;

  modport master (
    output screenEnd, p1_up, p1_down, p2_up, p2_down, winner,
    input  posEdgeScreenEnd,
    input  p1_leftBound, p1_rightBound, p2_leftBound, p2_rightBound,
    input  p1_topBound, p1_bottomBound, p2_topBound, p2_bottomBound
  );

  modport slave (
    input  screenEnd, p1_up, p1_down, p2_up, p2_down, winner,
    output posEdgeScreenEnd,
    output p1_leftBound, p1_rightBound, p2_leftBound, p2_rightBound,
    output p1_topBound, p1_bottomBound, p2_topBound, p2_bottomBound
  );

endinterface

// File: rtl/paddle_controller_button_sync.sv
// Two-flop synchronizer for one raw push-button, synchronous active-high reset.
module button_sync (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clock) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/paddle_controller.sv
// Per-frame paddle position update with playfield clamping and winner freeze.
// Optional hold-to-accelerate behaviour is enabled by defining PADDLE_ACCEL_EN.
module paddle_controller #(
  parameter int Y_MAX        = pong_pkg::Y_MAX,
  parameter int PADDLE_H     = pong_pkg::PADDLE_H,
  parameter int PADDLE_W     = pong_pkg::PADDLE_W,
  parameter int P1_X         = 16,
  parameter int P2_X         = 614,
  parameter int SPEED        = 4,
  parameter int ACCEL_FRAMES = 8
) (
  input  logic                clock,
  input  logic                reset,
  paddle_controller_if.slave  bus
);
  import pong_pkg::*;

  localparam int NUM_PADDLES = 2;
  localparam logic [X_W-1:0] TOP_MAX = X_W'(Y_MAX - PADDLE_H);
  localparam logic [Y_W-1:0] TOP_RST = Y_W'((Y_MAX - PADDLE_H) / 2);
  localparam logic [Y_W-1:0] BOT_OFS = Y_W'(PADDLE_H - 1);

  // Raw buttons packed as {p2_down, p2_up, p1_down, p1_up}: paddle p owns bits 2p (up), 2p+1 (down).
  logic [2*NUM_PADDLES-1:0] btn_raw;
  logic [2*NUM_PADDLES-1:0] btn_s;

  assign btn_raw = {bus.p2_down, bus.p2_up, bus.p1_down, bus.p1_up};

  for (genvar i = 0; i < 2*NUM_PADDLES; i++) begin : g_sync
    button_sync u_sync (
      .clock (clock),
      .reset (reset),
      .d     (btn_raw[i]),
      .q     (btn_s[i])
    );
  end

  logic screenEnd_d;
  logic strobe;

  always_ff @(posedge clock) begin
    if (reset) begin
      screenEnd_d <= 1'b0;
      strobe      <= 1'b0;
    end else begin
      screenEnd_d <= bus.screenEnd;
      strobe      <= bus.screenEnd & ~screenEnd_d;
    end
  end

  logic                       frozen;
  logic [NUM_PADDLES-1:0]     up, down;
  logic [NUM_PADDLES-1:0][X_W-1:0] step;
  logic [NUM_PADDLES-1:0][Y_W-1:0] top_q, bot_q, top_nxt;

  assign frozen = (bus.winner != WIN_NONE);

  always_comb begin
    for (int p = 0; p < NUM_PADDLES; p++) begin
      up[p]   = btn_s[2*p];
      down[p] = btn_s[2*p+1];
    end
  end

`ifdef PADDLE_ACCEL_EN
  localparam logic [4:0] ACC_TH = 5'(ACCEL_FRAMES);
  logic [NUM_PADDLES-1:0][3:0] hold_cnt;

  // Step depends on the count before this strobe, so the boost starts on frame ACCEL_FRAMES+1.
  always_comb begin
    for (int p = 0; p < NUM_PADDLES; p++)
      step[p] = ({1'b0, hold_cnt[p]} >= ACC_TH) ? X_W'(2*SPEED) : X_W'(SPEED);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hold_cnt <= '0;
    end else if (strobe) begin
      for (int p = 0; p < NUM_PADDLES; p++) begin
        if (frozen || !(up[p] ^ down[p]))
          hold_cnt[p] <= '0;
        else if (hold_cnt[p] != 4'hF)
          hold_cnt[p] <= hold_cnt[p] + 4'd1;
      end
    end
  end
`else
  logic unused_accel_frames;
  assign unused_accel_frames = ACCEL_FRAMES[0];

  always_comb begin
    for (int p = 0; p < NUM_PADDLES; p++)
      step[p] = X_W'(SPEED);
  end
`endif

  always_comb begin
    for (int p = 0; p < NUM_PADDLES; p++)
      top_nxt[p] = next_top(top_q[p], up[p], down[p], step[p], TOP_MAX);
  end

  // Both paddles share one update rule; top and bottom are registered together.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int p = 0; p < NUM_PADDLES; p++) begin
        top_q[p] <= TOP_RST;
        bot_q[p] <= TOP_RST + BOT_OFS;
      end
    end else if (strobe && !frozen) begin
      for (int p = 0; p < NUM_PADDLES; p++) begin
        top_q[p] <= top_nxt[p];
        bot_q[p] <= top_nxt[p] + BOT_OFS;
      end
    end
  end

  assign bus.posEdgeScreenEnd = strobe;
  assign bus.p1_leftBound     = X_W'(P1_X);
  assign bus.p1_rightBound    = X_W'(P1_X + PADDLE_W - 1);
  assign bus.p2_leftBound     = X_W'(P2_X);
  assign bus.p2_rightBound    = X_W'(P2_X + PADDLE_W - 1);
  assign bus.p1_topBound      = top_q[0];
  assign bus.p1_bottomBound   = bot_q[0];
  assign bus.p2_topBound      = top_q[1];
  assign bus.p2_bottomBound   = bot_q[1];

endmodule

// File: tb/tb_paddle_controller.sv
// Self-checking bench for paddle_controller: directed scenarios plus randomized frames vs a behavioural model.
module tb_paddle_controller;

  localparam int TOP_LIM = 416;
  localparam int H       = 64;
`ifdef PADDLE_ACCEL_EN
  localparam bit ACCEL = 1'b1;
`else
  localparam bit ACCEL = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;

  paddle_controller_if bus();

  paddle_controller dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  int strobe_cnt = 0;

  // Model state: paddle tops, hold lengths, current button levels {p1u,p1d,p2u,p2d}, winner.
  int m_top[2];
  int m_cnt[2];
  int m_btn[4];
  int m_winner;

  always @(negedge clock)
    if (bus.posEdgeScreenEnd === 1'b1) strobe_cnt++;

  task automatic model_reset();
    for (int p = 0; p < 2; p++) begin
      m_top[p] = 208;
      m_cnt[p] = 0;
    end
  endtask

  // One frame's worth of movement, straight from the movement rules.
  task automatic model_frame();
    for (int p = 0; p < 2; p++) begin
      int u, d, dir, stp, nt;
      u = m_btn[2*p];
      d = m_btn[2*p+1];
      dir = (u && !d) ? -1 : ((d && !u) ? 1 : 0);
      if (m_winner != 0) begin
        dir = 0;
        m_cnt[p] = 0;
      end
      stp = (ACCEL && m_cnt[p] >= 8) ? 8 : 4;
      nt = m_top[p] + dir * stp;
      if (nt < 0) nt = 0;
      if (nt > TOP_LIM) nt = TOP_LIM;
      m_top[p] = nt;
      m_cnt[p] = (dir != 0) ? ((m_cnt[p] < 15) ? m_cnt[p] + 1 : 15) : 0;
    end
  endtask

  task automatic set_btns(input int p1u, input int p1d, input int p2u, input int p2d);
    @(negedge clock);
    bus.p1_up = p1u[0]; bus.p1_down = p1d[0];
    bus.p2_up = p2u[0]; bus.p2_down = p2d[0];
    m_btn[0] = p1u; m_btn[1] = p1d; m_btn[2] = p2u; m_btn[3] = p2d;
  endtask

  // Buttons settle, screenEnd goes high for hi cycles, then low again.
  task automatic do_frame(input int hi);
    repeat (3) @(negedge clock);
    bus.screenEnd = 1'b1;
    repeat (hi) @(negedge clock);
    bus.screenEnd = 1'b0;
    repeat (3) @(negedge clock);
    model_frame();
  endtask

  task automatic apply_reset(input int cycles);
    @(negedge clock);
    reset = 1'b1;
    bus.screenEnd = 1'b0;
    repeat (cycles) @(negedge clock);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    bus.screenEnd = 1'b0; bus.winner = 2'd0;
    bus.p1_up = 0; bus.p1_down = 0; bus.p2_up = 0; bus.p2_down = 0;
    m_btn = '{0, 0, 0, 0}; m_winner = 0;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    total += 9;
    if (bus.p1_topBound !== 9'd208) begin bad++; $display("FAIL reset_p1_top: got %0d want 208", bus.p1_topBound); end
    if (bus.p1_bottomBound !== 9'd271) begin bad++; $display("FAIL reset_p1_bot: got %0d want 271", bus.p1_bottomBound); end
    if (bus.p2_topBound !== 9'd208) begin bad++; $display("FAIL reset_p2_top: got %0d want 208", bus.p2_topBound); end
    if (bus.p2_bottomBound !== 9'd271) begin bad++; $display("FAIL reset_p2_bot: got %0d want 271", bus.p2_bottomBound); end
    if (bus.p1_leftBound !== 10'd16) begin bad++; $display("FAIL reset_p1_left: got %0d want 16", bus.p1_leftBound); end
    if (bus.p1_rightBound !== 10'd25) begin bad++; $display("FAIL reset_p1_right: got %0d want 25", bus.p1_rightBound); end
    if (bus.p2_leftBound !== 10'd614) begin bad++; $display("FAIL reset_p2_left: got %0d want 614", bus.p2_leftBound); end
    if (bus.p2_rightBound !== 10'd623) begin bad++; $display("FAIL reset_p2_right: got %0d want 623", bus.p2_rightBound); end
    if (bus.posEdgeScreenEnd !== 1'b0) begin bad++; $display("FAIL reset_strobe: got %0b want 0", bus.posEdgeScreenEnd); end
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_p1_up();
    int old_top;
    set_btns(1, 0, 0, 0);
    for (int f = 0; f < 3; f++) begin
      repeat (3) @(negedge clock);
      old_top = m_top[0];
      bus.screenEnd = 1'b1;
      @(posedge clock); #1;
      total += 2;
      if (bus.posEdgeScreenEnd !== 1'b1) begin bad++; $display("FAIL up_strobe_hi f%0d: got %0b want 1", f, bus.posEdgeScreenEnd); end
      if (bus.p1_topBound !== 9'(old_top)) begin bad++; $display("FAIL up_top_in_strobe f%0d: got %0d want %0d", f, bus.p1_topBound, old_top); end
      model_frame();
      @(posedge clock); #1;
      total += 3;
      if (bus.posEdgeScreenEnd !== 1'b0) begin bad++; $display("FAIL up_strobe_lo f%0d: got %0b want 0", f, bus.posEdgeScreenEnd); end
      if (bus.p1_topBound !== 9'(m_top[0])) begin bad++; $display("FAIL up_top_after f%0d: got %0d want %0d", f, bus.p1_topBound, m_top[0]); end
      if (bus.p1_bottomBound !== 9'(m_top[0] + H - 1)) begin bad++; $display("FAIL up_bot_after f%0d: got %0d want %0d", f, bus.p1_bottomBound, m_top[0] + H - 1); end
      @(negedge clock);
      bus.screenEnd = 1'b0;
    end
    total += 3;
    if (bus.p1_topBound !== 9'd196) begin bad++; $display("FAIL up_final_top: got %0d want 196", bus.p1_topBound); end
    if (bus.p1_bottomBound !== 9'd259) begin bad++; $display("FAIL up_final_bot: got %0d want 259", bus.p1_bottomBound); end
    if (bus.p2_topBound !== 9'd208) begin bad++; $display("FAIL up_p2_still: got %0d want 208", bus.p2_topBound); end
  endtask

  task automatic test_saturate();
    set_btns(0, 0, 0, 1);
    for (int f = 0; f < 60; f++) do_frame(2);
    total += 2;
    if (bus.p2_topBound !== 9'd416) begin bad++; $display("FAIL sat_p2_top: got %0d want 416", bus.p2_topBound); end
    if (bus.p2_bottomBound !== 9'd479) begin bad++; $display("FAIL sat_p2_bot: got %0d want 479", bus.p2_bottomBound); end
    set_btns(1, 0, 0, 0);
    for (int f = 0; f < 60; f++) do_frame(2);
    total += 3;
    if (bus.p1_topBound !== 9'd0) begin bad++; $display("FAIL sat_p1_top: got %0d want 0", bus.p1_topBound); end
    if (bus.p1_bottomBound !== 9'd63) begin bad++; $display("FAIL sat_p1_bot: got %0d want 63", bus.p1_bottomBound); end
    if (bus.p2_topBound !== 9'd416) begin bad++; $display("FAIL sat_p2_stays: got %0d want 416", bus.p2_topBound); end
  endtask

  task automatic test_strobe_and_hold();
    int c0;
    apply_reset(2);
    set_btns(1, 1, 0, 0);
    c0 = strobe_cnt;
    do_frame(50);
    total += 2;
    if (strobe_cnt - c0 !== 1) begin bad++; $display("FAIL long_high_strobes: got %0d want 1", strobe_cnt - c0); end
    if (bus.p1_topBound !== 9'd208) begin bad++; $display("FAIL both_buttons_hold: got %0d want 208", bus.p1_topBound); end
    // Button pulse confined to the gap between strobes.
    set_btns(0, 0, 0, 0);
    set_btns(0, 1, 0, 0);
    set_btns(0, 0, 0, 0);
    do_frame(2);
    total += 1;
    if (bus.p1_topBound !== 9'd208) begin bad++; $display("FAIL glitch_no_move: got %0d want 208", bus.p1_topBound); end
  endtask

  task automatic test_winner_and_reset();
    int c0;
    apply_reset(2);
    @(negedge clock);
    bus.winner = 2'd1; m_winner = 1;
    set_btns(0, 1, 0, 0);
    for (int f = 0; f < 5; f++) do_frame(2);
    total += 1;
    if (bus.p1_topBound !== 9'd208) begin bad++; $display("FAIL winner_freeze: got %0d want 208", bus.p1_topBound); end
    @(negedge clock);
    bus.winner = 2'd0; m_winner = 0;
    do_frame(2);
    total += 1;
    if (bus.p1_topBound !== 9'd212) begin bad++; $display("FAIL winner_release: got %0d want 212", bus.p1_topBound); end
    // Reset lands in the strobe cycle.
    repeat (3) @(negedge clock);
    bus.screenEnd = 1'b1;
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    total += 3;
    if (bus.posEdgeScreenEnd !== 1'b0) begin bad++; $display("FAIL rst_strobe_drop: got %0b want 0", bus.posEdgeScreenEnd); end
    if (bus.p1_topBound !== 9'd208) begin bad++; $display("FAIL rst_in_strobe_top: got %0d want 208", bus.p1_topBound); end
    if (bus.p1_bottomBound !== 9'd271) begin bad++; $display("FAIL rst_in_strobe_bot: got %0d want 271", bus.p1_bottomBound); end
    // screenEnd still high when reset releases: one strobe, but synchronizers are cleared.
    set_btns(0, 0, 0, 0);
    c0 = strobe_cnt;
    reset = 1'b0;
    model_reset();
    @(posedge clock); #1;
    total += 1;
    if (bus.posEdgeScreenEnd !== 1'b1) begin bad++; $display("FAIL release_high_strobe: got %0b want 1", bus.posEdgeScreenEnd); end
    repeat (10) @(negedge clock);
    bus.screenEnd = 1'b0;
    repeat (3) @(negedge clock);
    total += 2;
    if (strobe_cnt - c0 !== 1) begin bad++; $display("FAIL release_high_count: got %0d want 1", strobe_cnt - c0); end
    if (bus.p1_topBound !== 9'd208) begin bad++; $display("FAIL release_high_top: got %0d want 208", bus.p1_topBound); end
  endtask

  task automatic test_accel();
    int exp_top;
    apply_reset(2);
    set_btns(0, 1, 0, 0);
    for (int f = 1; f <= 9; f++) begin
      do_frame(2);
      exp_top = (ACCEL && f == 9) ? 248 : 208 + 4 * f;
      total += 1;
      if (bus.p1_topBound !== 9'(exp_top)) begin bad++; $display("FAIL accel_frame%0d: got %0d want %0d", f, bus.p1_topBound, exp_top); end
    end
    set_btns(0, 0, 0, 0);
    do_frame(2);
    set_btns(0, 1, 0, 0);
    do_frame(2);
    exp_top = ACCEL ? 252 : 248;
    total += 1;
    if (bus.p1_topBound !== 9'(exp_top)) begin bad++; $display("FAIL accel_restart: got %0d want %0d", bus.p1_topBound, exp_top); end
  endtask

  task automatic test_random();
    int c0, b;
    apply_reset(2);
    for (int f = 0; f < 80; f++) begin
      b = int'($urandom_range(0, 15));
      set_btns(b & 1, (b >> 1) & 1, (b >> 2) & 1, (b >> 3) & 1);
      m_winner = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 2)) : 0;
      bus.winner = 2'(m_winner);
      c0 = strobe_cnt;
      do_frame(int'($urandom_range(1, 6)));
      total += 5;
      if (strobe_cnt - c0 !== 1) begin bad++; $display("FAIL rnd_strobes f%0d: got %0d want 1", f, strobe_cnt - c0); end
      if (bus.p1_topBound !== 9'(m_top[0])) begin bad++; $display("FAIL rnd_p1_top f%0d: got %0d want %0d", f, bus.p1_topBound, m_top[0]); end
      if (bus.p1_bottomBound !== 9'(m_top[0] + H - 1)) begin bad++; $display("FAIL rnd_p1_bot f%0d: got %0d want %0d", f, bus.p1_bottomBound, m_top[0] + H - 1); end
      if (bus.p2_topBound !== 9'(m_top[1])) begin bad++; $display("FAIL rnd_p2_top f%0d: got %0d want %0d", f, bus.p2_topBound, m_top[1]); end
      if (bus.p2_bottomBound !== 9'(m_top[1] + H - 1)) begin bad++; $display("FAIL rnd_p2_bot f%0d: got %0d want %0d", f, bus.p2_bottomBound, m_top[1] + H - 1); end
    end
    bus.winner = 2'd0; m_winner = 0;
  endtask

  initial begin
    test_reset();
    test_p1_up();
    test_saturate();
    test_strobe_and_hold();
    test_winner_and_reset();
    test_accel();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
